// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory-port arbiter.
package arm_mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Requester identifiers, also the encoding of grant_src.
  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_DM = 1'b1;

  // Width of the memory latency down-counter (MEM_LAT up to 15).
  localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline-side request ports and the memory-side port.
//
// Handshake: a requester raises *_req with its address (and store data) and
// keeps it high until it sees the one-cycle *_ready pulse; the arbiter
// latches the request when it grants it, so later changes of the request
// fields (or dropping *_req) do not affect the access already in flight.
// *_rdata is valid in the *_ready cycle and holds until the next read of
// that source. On the memory side mem_en is a single-cycle strobe per access
// and mem_rdata is expected exactly MEM_LAT cycles after that strobe.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import arm_mem_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              if_stall;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ready;
  logic              dm_stall;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              grant_src;
  arb_state_t        dbg_state;

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy, grant_src, dbg_state
  );

  // Pipeline plus memory side.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, if_stall, dm_rdata, dm_ready, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, busy, grant_src, dbg_state
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between IF and DM plus the IF starvation counter.
module mem_arb_pick
  import arm_mem_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_en,
  output logic winner
);

  localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  logic [CW-1:0] starve_cnt;
  logic          force_if;

  // DM wins a tie unless IF has waited through STARVE_LIM DM grants.
  always_comb begin
    force_if = (STARVE_LIM != 0) && (starve_cnt == LIM);
    winner   = SRC_IF;
    if (dm_req && !(if_req && force_if)) begin
      winner = SRC_DM;
    end
  end

  // Count DM grants that left IF waiting; saturate at the limit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_en) begin
      if (winner == SRC_DM && if_req) begin
        if (starve_cnt != LIM) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-ported memory between IF and DM.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_t        state, state_nxt;
  logic              lat_src;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [LAT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              grant_src_q;
  logic              winner;
  logic              grant_en;

  assign grant_en = (state == IDLE) && (bus.if_req || bus.dm_req);

  mem_arb_pick #(
    .STARVE_LIM(STARVE_LIM)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
    .grant_en(grant_en),
    .winner  (winner)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: writes skip the latency wait, reads wait out MEM_LAT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_en) state_nxt = ISSUE;
      ISSUE:   state_nxt = lat_we ? RESP : WAIT;
      WAIT:    if (wait_cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the granted request so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_src     <= SRC_IF;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      grant_src_q <= SRC_IF;
    end else if (grant_en) begin
      lat_src     <= winner;
      grant_src_q <= winner;
      if (winner == SRC_DM) begin
        lat_we    <= bus.dm_we;
        lat_addr  <= bus.dm_addr;
        lat_wdata <= bus.dm_wdata;
      end else begin
        lat_we    <= 1'b0;
        lat_addr  <= bus.if_addr;
        lat_wdata <= '0;
      end
    end
  end

  // Latency counter: loaded at issue, reaches zero MEM_LAT cycles later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= LAT_W'(MEM_LAT - 1);
    end else if (state == WAIT && wait_cnt != '0) begin
      wait_cnt <= wait_cnt - 1'b1;
    end
  end

  // Capture read data into the owning source's register only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (state == WAIT && wait_cnt == '0) begin
      if (lat_src == SRC_DM) begin
        dm_rdata_q <= bus.mem_rdata;
      end else begin
        if_rdata_q <= bus.mem_rdata;
      end
    end
  end

  // FSM outputs: memory strobe only in ISSUE, ready pulse only in RESP.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.if_ready  = 1'b0;
    bus.dm_ready  = 1'b0;
    if (state == ISSUE) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = lat_we;
      bus.mem_addr  = lat_addr;
      bus.mem_wdata = lat_wdata;
    end
    if (state == RESP) begin
      bus.if_ready = (lat_src == SRC_IF);
      bus.dm_ready = (lat_src == SRC_DM);
    end
  end

  assign bus.if_stall  = bus.if_req & ~bus.if_ready;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_ready;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.grant_src = grant_src_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT=2/STARVE_LIM=4 and
// MEM_LAT=1/STARVE_LIM=0), each with a latency memory and a transaction-level
// reference model, plus directed and random stimulus.
module tb_mem_port_arbiter;
  import arm_mem_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  logic          if_req   [2];
  logic [AW-1:0] if_addr  [2];
  logic          dm_req   [2];
  logic          dm_we    [2];
  logic [AW-1:0] dm_addr  [2];
  logic [DW-1:0] dm_wdata [2];

  logic          if_ready_o [2];
  logic          if_stall_o [2];
  logic          dm_ready_o [2];
  logic          dm_stall_o [2];
  logic          mem_en_o   [2];
  logic          mem_we_o   [2];
  logic          busy_o     [2];
  logic          gsrc_o     [2];
  logic [DW-1:0] if_rdata_o [2];
  logic [DW-1:0] dm_rdata_o [2];
  logic [DW-1:0] mem_wdata_o[2];
  logic [AW-1:0] mem_addr_o [2];

  bit seen_if[2];
  bit seen_dm[2];
  logic seq_a[16];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    if (a == 3) return 32'hEAFFFFFF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- DUTs, memories, reference models ----------------
  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 2 : 1;
    localparam int LIM = (g == 0) ? 4 : 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .STARVE_LIM(LIM)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    assign bus.if_req   = if_req[g];
    assign bus.if_addr  = if_addr[g];
    assign bus.dm_req   = dm_req[g];
    assign bus.dm_we    = dm_we[g];
    assign bus.dm_addr  = dm_addr[g];
    assign bus.dm_wdata = dm_wdata[g];

    assign if_ready_o[g]  = bus.if_ready;
    assign if_stall_o[g]  = bus.if_stall;
    assign dm_ready_o[g]  = bus.dm_ready;
    assign dm_stall_o[g]  = bus.dm_stall;
    assign mem_en_o[g]    = bus.mem_en;
    assign mem_we_o[g]    = bus.mem_we;
    assign busy_o[g]      = bus.busy;
    assign gsrc_o[g]      = bus.grant_src;
    assign if_rdata_o[g]  = bus.if_rdata;
    assign dm_rdata_o[g]  = bus.dm_rdata;
    assign mem_wdata_o[g] = bus.mem_wdata;
    assign mem_addr_o[g]  = bus.mem_addr;

    logic [DW-1:0] dut_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    logic          pipe_v [32];
    logic [DW-1:0] pipe_d [32];

    // Reference model: one transaction record with its grant and response cycles.
    bit            m_act;
    int unsigned   t0, t_resp;
    logic          m_src, m_we, m_gsrc;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_data, m_if_rd, m_dm_rd;
    int            starve;

    always @(negedge clk) begin
      logic          e_en, e_we, e_ir, e_dr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      int unsigned   c;
      c = cyc;
      if (!rst) begin
        m_act = 0; m_if_rd = '0; m_dm_rd = '0; m_gsrc = 1'b0; starve = 0;
        for (int i = 0; i < 32; i++) pipe_v[i] = 1'b0;
      end else if (m_act && c > t_resp) begin
        m_act = 0;
      end
      if (m_act && c == t_resp && !m_we) begin
        if (m_src) m_dm_rd = m_data;
        else       m_if_rd = m_data;
      end

      e_en   = m_act && (c == t0 + 1);
      e_we   = e_en && m_we;
      e_addr = e_en ? m_addr : '0;
      e_wd   = e_we ? m_wdata : '0;
      e_ir   = m_act && (c == t_resp) && !m_src;
      e_dr   = m_act && (c == t_resp) && m_src;

      chk($sformatf("i%0d busy", g), bus.busy, m_act);
      chk($sformatf("i%0d mem_en", g), bus.mem_en, e_en);
      chk($sformatf("i%0d mem_we", g), bus.mem_we, e_we);
      chk($sformatf("i%0d mem_addr", g), bus.mem_addr, e_addr);
      if (!e_en || e_we) chk($sformatf("i%0d mem_wdata", g), bus.mem_wdata, e_wd);
      chk($sformatf("i%0d if_ready", g), bus.if_ready, e_ir);
      chk($sformatf("i%0d dm_ready", g), bus.dm_ready, e_dr);
      chk($sformatf("i%0d if_stall", g), bus.if_stall, if_req[g] & ~e_ir);
      chk($sformatf("i%0d dm_stall", g), bus.dm_stall, dm_req[g] & ~e_dr);
      chk($sformatf("i%0d if_rdata", g), bus.if_rdata, m_if_rd);
      chk($sformatf("i%0d dm_rdata", g), bus.dm_rdata, m_dm_rd);
      chk($sformatf("i%0d grant_src", g), bus.grant_src, m_gsrc);

      if (rst && !m_act && (if_req[g] || dm_req[g])) begin
        if (if_req[g] && dm_req[g]) m_src = (LIM != 0 && starve == LIM) ? SRC_IF : SRC_DM;
        else                        m_src = dm_req[g];
        if (m_src == SRC_DM && if_req[g]) starve = (starve < LIM) ? starve + 1 : LIM;
        else                              starve = 0;
        m_we    = m_src ? dm_we[g] : 1'b0;
        m_addr  = m_src ? dm_addr[g] : if_addr[g];
        m_wdata = dm_wdata[g];
        if (m_we) ref_mem[m_addr] = m_wdata;
        else      m_data = ref_mem.exists(m_addr) ? ref_mem[m_addr] : init_word(m_addr);
        t0     = c;
        t_resp = m_we ? c + 2 : c + LAT + 2;
        m_act  = 1;
        m_gsrc = m_src;
      end

      // Latency memory: data appears only in the cycle exactly LAT after mem_en.
      if (rst && bus.mem_en) begin
        if (bus.mem_we) begin
          dut_mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          pipe_v[(c + LAT) % 32] = 1'b1;
          pipe_d[(c + LAT) % 32] = dut_mem.exists(bus.mem_addr) ? dut_mem[bus.mem_addr]
                                                                 : init_word(bus.mem_addr);
        end
      end
      if (pipe_v[c % 32]) begin
        bus.mem_rdata = pipe_d[c % 32];
        pipe_v[c % 32] = 1'b0;
      end else begin
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1'b0; dm_req[i] = 1'b0; dm_we[i] = 1'b0;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 1024;
    return AW'($urandom_range(0, 15));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int nif, ndm, ga, gb, gb_if, stale;
    bit got_if, got_dm, got;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 0; if_addr[i] = '0; dm_req[i] = 0; dm_we[i] = 0;
      dm_addr[i] = '0; dm_wdata[i] = '0;
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy_o[0], 0);
    chk("reset mem_en", mem_en_o[0], 0);
    chk("reset if_rdata", if_rdata_o[0], 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();

    // Read latency on both instances (MEM_LAT 2 and 1).
    if_req[0] = 1; if_addr[0] = 3; if_req[1] = 1; if_addr[1] = 3;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k <= 3) chk("lat2 if_stall", if_stall_o[0], 1);
      if (k == 1) begin
        chk("lat2 mem_en", mem_en_o[0], 1);
        chk("lat2 mem_addr", mem_addr_o[0], 3);
        chk("lat1 mem_en", mem_en_o[1], 1);
      end
      if (k == 2) chk("lat1 early ready", if_ready_o[1], 0);
      if (k == 3) begin
        chk("lat2 early ready", if_ready_o[0], 0);
        chk("lat1 if_ready", if_ready_o[1], 1);
        chk("lat1 if_rdata", if_rdata_o[1], 32'hEAFFFFFF);
      end
      if (k == 4) begin
        chk("lat2 if_ready", if_ready_o[0], 1);
        chk("lat2 if_rdata", if_rdata_o[0], 32'hEAFFFFFF);
      end
      tick();
      if (k == 3) if_req[1] = 0;
    end
    if_req[0] = 0;

    // Store then load of word 1024.
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 1024; dm_wdata[0] = 8192;
    for (int k = 0; k <= 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("store mem_en", mem_en_o[0], 1);
        chk("store mem_we", mem_we_o[0], 1);
        chk("store mem_wdata", mem_wdata_o[0], 8192);
      end
      if (k == 2) begin
        chk("store dm_ready", dm_ready_o[0], 1);
        chk("store keeps dm_rdata", dm_rdata_o[0], 0);
      end
      tick();
    end
    dm_req[0] = 0; dm_we[0] = 0;
    tick();
    dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 1024; dm_wdata[0] = 32'hDEAD0000;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k == 4) begin
        chk("load dm_ready", dm_ready_o[0], 1);
        chk("load dm_rdata", dm_rdata_o[0], 8192);
      end
      tick();
      if (k == 0) dm_addr[0] = 7;
    end
    dm_req[0] = 0;

    // Simultaneous requests: DM first, then IF, one pulse each.
    nif = 0; ndm = 0; got_if = 0; got_dm = 0;
    if_req[0] = 1; if_addr[0] = 9; dm_req[0] = 1; dm_we[0] = 0; dm_addr[0] = 1024;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 1) chk("tie first grant", gsrc_o[0], 1);
      if (k == 6) chk("tie second grant", gsrc_o[0], 0);
      if (if_ready_o[0]) begin nif++; got_if = 1; end
      if (dm_ready_o[0]) begin ndm++; got_dm = 1; end
      tick();
      if (got_if) if_req[0] = 0;
      if (got_dm) dm_req[0] = 0;
    end
    chk("tie if pulses", nif, 1);
    chk("tie dm pulses", ndm, 1);

    // Starvation: both requests held continuously.
    ga = 0; gb = 0; gb_if = 0;
    for (int i = 0; i < 2; i++) begin
      if_req[i] = 1; if_addr[i] = 2;
      dm_req[i] = 1; dm_we[i] = 1; dm_addr[i] = 5; dm_wdata[i] = $urandom;
    end
    for (int k = 0; k < 150 && ga < 10; k++) begin
      @(negedge clk);
      if (mem_en_o[0]) begin seq_a[ga] = gsrc_o[0]; ga++; end
      if (mem_en_o[1]) begin gb++; if (gsrc_o[1] == SRC_IF) gb_if++; end
      tick();
    end
    idle_all();
    chk("starve grant count", ga, 10);
    for (int n = 0; n < ga; n++) chk($sformatf("starve grant %0d", n), seq_a[n], (n % 5 == 4) ? 0 : 1);
    chk("lim0 if grants", gb_if, 0);
    chk("lim0 progress", gb >= 5, 1);
    repeat (10) tick();

    // Random traffic on both instances.
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin seen_if[i] = if_ready_o[i]; seen_dm[i] = dm_ready_o[i]; end
      tick();
      for (int i = 0; i < 2; i++) begin
        if (if_req[i]) begin
          if (seen_if[i] && $urandom_range(0, 3) != 0) if_req[i] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          if_req[i] = 1; if_addr[i] = rand_addr();
        end
        if (dm_req[i]) begin
          if (seen_dm[i] && $urandom_range(0, 3) != 0) dm_req[i] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          dm_req[i] = 1; dm_we[i] = $urandom_range(0, 1) == 1;
          dm_addr[i] = rand_addr(); dm_wdata[i] = $urandom;
        end
        if ($urandom_range(0, 7) == 0) begin
          if_addr[i] = rand_addr(); dm_addr[i] = rand_addr(); dm_wdata[i] = $urandom;
        end
        if ($urandom_range(0, 31) == 0) begin if_req[i] = 0; dm_req[i] = 0; end
      end
    end
    idle_all();
    repeat (10) tick();

    // Reset in the middle of a read wait.
    if_req[0] = 1; if_addr[0] = 77; if_req[1] = 1; if_addr[1] = 77;
    tick();
    tick();
    chk("pre-reset busy", busy_o[0], 1);
    rst = 1'b0; if_req[0] = 0; if_req[1] = 0;
    #1;
    chk("async reset mem_en", mem_en_o[0], 0);
    chk("async reset busy a", busy_o[0], 0);
    chk("async reset busy b", busy_o[1], 0);
    chk("async reset if_rdata", if_rdata_o[0], 0);
    chk("async reset dm_rdata", dm_rdata_o[0], 0);
    chk("async reset if_stall", if_stall_o[0], 0);
    repeat (2) tick();
    rst = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_ready_o[0] || if_ready_o[1]) stale++;
      tick();
    end
    chk("no stale ready", stale, 0);
    got = 0;
    if_req[0] = 1; if_addr[0] = 77;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (if_ready_o[0]) begin
        got = 1;
        chk("post-reset if_rdata", if_rdata_o[0], init_word(77));
      end
      tick();
    end
    if_req[0] = 0;
    chk("post-reset completed", got, 1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
